// File: rtl/gold_code_sequencer.sv
// gold_code_sequencer
//   Sequences a two-LFSR Gold code generator. It takes START / STOP / ADVANCE /
//   RETARD commands over a valid/ready handshake. It drives the generator's
//   load pulse, seed and step enable at the chip rate. It also tracks which chip
//   index is currently on the generator output.
//
// Ports
//   clk, rst        : system clock, asynchronous active-high reset
//   chip_en         : one-cycle chip-rate strobe
//   cmd_valid/ready : command handshake; accepted on valid && ready at the edge
//   cmd_op          : 00 START, 01 STOP, 10 ADVANCE, 11 RETARD
//   cmd_code        : B-register seed (START)
//   cmd_arg         : chip count (ADVANCE / RETARD)
//   gen_load        : one-cycle load pulse to the generator
//   gen_seed        : registered seed presented to the generator
//   gen_step        : generator shift enable for this cycle (combinational)
//   chip_count      : index of the chip currently on the generator output
//   epoch           : high in the cycle whose step wraps chip_count to 0
//   running         : high in RUN, ADV and HOLD
module gold_code_sequencer #(
    parameter int CODE_LEN = 32767,
    parameter int CNT_W    = 15,
    parameter int ARG_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chip_en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [5:0]       cmd_code,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic             gen_load,
    output logic [5:0]       gen_seed,
    output logic             gen_step,
    output logic [CNT_W-1:0] chip_count,
    output logic             epoch,
    output logic             running
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_ADV,
        S_HOLD
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_ADV   = 2'b10;
    localparam logic [1:0] OP_RET   = 2'b11;

    localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CODE_LEN - 1);
    localparam logic [ARG_W-1:0] ARG_ONE   = ARG_W'(1);
    localparam logic [ARG_W-1:0] ARG_ZERO  = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] chip_count_q, chip_count_d;
    logic [5:0]       gen_seed_q, gen_seed_d;
    logic [ARG_W-1:0] adv_cnt_q, adv_cnt_d;
    logic [ARG_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             accept;

    // Outputs decoded straight from state so a step lands in the same cycle
    // as the chip_en that caused it.
    assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_RUN);
    assign gen_step   = ((state_q == S_RUN) && chip_en) || (state_q == S_ADV);
    assign gen_load   = (state_q == S_LOAD);
    assign running    = (state_q == S_RUN) || (state_q == S_ADV) || (state_q == S_HOLD);
    assign epoch      = gen_step && (chip_count_q == LAST_CHIP);
    assign chip_count = chip_count_q;
    assign gen_seed   = gen_seed_q;
    assign accept     = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        chip_count_d = chip_count_q;
        gen_seed_d   = gen_seed_q;
        adv_cnt_d    = adv_cnt_q;
        hold_cnt_d   = hold_cnt_q;

        // chip_count follows every generator shift, so it always matches the
        // generator phase.
        if (gen_step) begin
            chip_count_d = (chip_count_q == LAST_CHIP) ? '0 : chip_count_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // STOP, ADVANCE and RETARD are accepted here but do nothing.
                if (accept && cmd_op == OP_START) begin
                    gen_seed_d = cmd_code;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                chip_count_d = '0;
                state_d      = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_START: begin
                            gen_seed_d = cmd_code;
                            state_d    = S_LOAD;
                        end
                        OP_STOP: state_d = S_IDLE;
                        OP_ADV: begin
                            if (cmd_arg != ARG_ZERO) begin
                                adv_cnt_d = cmd_arg;
                                state_d   = S_ADV;
                            end
                        end
                        OP_RET: begin
                            if (cmd_arg != ARG_ZERO) begin
                                hold_cnt_d = cmd_arg;
                                state_d    = S_HOLD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_ADV: begin
                // One forced step per cycle. chip_en in this window is dropped.
                adv_cnt_d = adv_cnt_q - ARG_ONE;
                if (adv_cnt_q == ARG_ONE) state_d = S_RUN;
            end
            S_HOLD: begin
                // Each swallowed chip_en delays the code by one chip.
                if (chip_en) begin
                    hold_cnt_d = hold_cnt_q - ARG_ONE;
                    if (hold_cnt_q == ARG_ONE) state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            chip_count_q <= '0;
            gen_seed_q   <= '0;
            adv_cnt_q    <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            chip_count_q <= chip_count_d;
            gen_seed_q   <= gen_seed_d;
            adv_cnt_q    <= adv_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_gold_code_sequencer.sv
module tb_gold_code_sequencer;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_ADV   = 2'b10;
    localparam logic [1:0] OP_RET   = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        chip_en, cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_code;
    logic [7:0]  cmd_arg;
    logic        gen_load, gen_step, epoch, running;
    logic [5:0]  gen_seed;
    logic [14:0] chip_count;

    // Short-period instance for wrap / epoch checks.
    logic        s_chip_en, s_cmd_valid, s_cmd_ready;
    logic [1:0]  s_cmd_op;
    logic [5:0]  s_cmd_code;
    logic [7:0]  s_cmd_arg;
    logic        s_gen_load, s_gen_step, s_epoch, s_running;
    logic [5:0]  s_gen_seed;
    logic [2:0]  s_chip_count;

    always #5 clk = ~clk;

    gold_code_sequencer #(.CODE_LEN(32767), .CNT_W(15), .ARG_W(8)) dut (
        .clk(clk), .rst(rst), .chip_en(chip_en), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_code(cmd_code),
        .cmd_arg(cmd_arg), .gen_load(gen_load), .gen_seed(gen_seed),
        .gen_step(gen_step), .chip_count(chip_count), .epoch(epoch),
        .running(running)
    );

    gold_code_sequencer #(.CODE_LEN(7), .CNT_W(3), .ARG_W(8)) dut7 (
        .clk(clk), .rst(rst), .chip_en(s_chip_en), .cmd_valid(s_cmd_valid),
        .cmd_ready(s_cmd_ready), .cmd_op(s_cmd_op), .cmd_code(s_cmd_code),
        .cmd_arg(s_cmd_arg), .gen_load(s_gen_load), .gen_seed(s_gen_seed),
        .gen_step(s_gen_step), .chip_count(s_chip_count), .epoch(s_epoch),
        .running(s_running)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int cnt;
        bit ep;
    } step_t;
    step_t sb[$];

    typedef struct {
        bit       en;
        bit [2:0] cnt;
        bit       ep;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_step(input int cnt);
        step_t t;
        t.cnt = cnt;
        t.ep  = 1'b0;
        sb.push_back(t);
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] code, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_code  = code;
        cmd_arg   = arg;
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_step(input int cnt_before);
        chip_en = 1'b1;
        push_step(cnt_before);
        cyc();
        chip_en = 1'b0;
    endtask

    // Scoreboard: every gen_step must match an expectation queued by the stimulus.
    always @(negedge clk) begin
        step_t e;
        if (gen_step === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_step: gen_step=1 at chip_count=%0d, expected gen_step=0", chip_count);
            end else begin
                e = sb.pop_front();
                chk("step_count", chip_count, e.cnt);
                chk("step_epoch", epoch, e.ep);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[17] = '{
            '{1, 1, 0}, '{1, 2, 0}, '{1, 3, 0}, '{0, 3, 0},
            '{1, 4, 0}, '{1, 5, 0}, '{1, 6, 0}, '{1, 0, 1},
            '{1, 1, 0}, '{1, 2, 0}, '{1, 3, 0}, '{0, 3, 0},
            '{1, 4, 0}, '{1, 5, 0}, '{1, 6, 0}, '{1, 0, 1},
            '{1, 1, 0}
        };

        rst = 1'b1;
        chip_en = 0; cmd_valid = 0; cmd_op = 0; cmd_code = 0; cmd_arg = 0;
        s_chip_en = 0; s_cmd_valid = 0; s_cmd_op = 0; s_cmd_code = 0; s_cmd_arg = 0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_load", gen_load, 0);
        chk("rst_step", gen_step, 0);
        chk("rst_epoch", epoch, 0);
        chk("rst_running", running, 0);
        chk("rst_count", chip_count, 0);
        chk("rst_seed", gen_seed, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // CODE_LEN=7 wrap / epoch table
        s_cmd_valid = 1'b1;
        s_cmd_op    = OP_START;
        s_cmd_code  = 6'h01;
        cyc();
        s_cmd_valid = 1'b0;
        cyc();
        for (int k = 0; k < 17; k++) begin
            s_chip_en = tbl[k].en;
            @(negedge clk);
            chk("e7_step", s_gen_step, tbl[k].en);
            chk("e7_epoch", s_epoch, tbl[k].ep);
            cyc();
            s_chip_en = 1'b0;
            chk("e7_count", s_chip_count, tbl[k].cnt);
        end

        // START seed 5, 20 chip pulses every 4th cycle
        send(OP_START, 6'h05, 8'd0);
        @(negedge clk);
        chk("load_pulse", gen_load, 1);
        chk("load_seed", gen_seed, 5);
        chk("load_ready", cmd_ready, 0);
        cyc();
        @(negedge clk);
        chk("run_load_done", gen_load, 0);
        chk("run_running", running, 1);
        chk("run_count0", chip_count, 0);
        for (int i = 0; i < 20; i++) begin
            pulse_step(i);
            repeat (3) cyc();
        end
        @(negedge clk);
        chk("run_count20", chip_count, 20);

        // Restart from RUN, step to 3, then ADVANCE 10 with chip_en toggling
        cyc();
        send(OP_START, 6'h05, 8'd0);
        cyc();
        for (int i = 0; i < 3; i++) pulse_step(i);
        send(OP_ADV, 6'h00, 8'd10);
        for (int i = 0; i < 10; i++) begin
            chip_en = (i % 2 == 1);
            push_step(3 + i);
            @(negedge clk);
            chk("adv_ready", cmd_ready, 0);
            cyc();
        end
        chip_en = 1'b0;
        @(negedge clk);
        chk("adv_ready_back", cmd_ready, 1);
        chk("adv_count13", chip_count, 13);
        cyc();

        // RETARD 3, five pulses: first three swallowed
        send(OP_RET, 6'h00, 8'd3);
        for (int i = 0; i < 5; i++) begin
            chip_en = 1'b1;
            if (i >= 3) push_step(13 + i - 3);
            @(negedge clk);
            chk("hold_ready", cmd_ready, (i >= 3) ? 1 : 0);
            cyc();
            chip_en = 1'b0;
            cyc();
        end
        @(negedge clk);
        chk("ret_count15", chip_count, 15);
        cyc();

        // STOP, chip pulses ignored, count held
        send(OP_STOP, 6'h00, 8'd0);
        @(negedge clk);
        chk("stop_running", running, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chip_en = 1'b1;
            cyc();
            chip_en = 1'b0;
            cyc();
        end
        @(negedge clk);
        chk("stop_count15", chip_count, 15);
        cyc();

        // ADVANCE in IDLE has no effect
        send(OP_ADV, 6'h00, 8'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_adv_ready", cmd_ready, 1);
            chk("idle_adv_running", running, 0);
            cyc();
        end
        chk("idle_adv_count", chip_count, 15);

        // START with cmd_valid held through LOAD: the next command waits for RUN
        cmd_valid = 1'b1;
        cmd_op    = OP_START;
        cmd_code  = 6'h09;
        @(negedge clk);
        chk("hold_start_ready", cmd_ready, 1);
        cyc();
        cmd_op  = OP_ADV;
        cmd_arg = 8'd2;
        @(negedge clk);
        chk("held_load_ready", cmd_ready, 0);
        chk("held_load_pulse", gen_load, 1);
        chk("held_load_seed", gen_seed, 9);
        cyc();
        @(negedge clk);
        chk("held_run_ready", cmd_ready, 1);
        chk("held_run_count", chip_count, 0);
        push_step(0);
        push_step(1);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("held_adv_count", chip_count, 2);
        cyc();

        // Zero-length ADVANCE / RETARD are no-ops
        send(OP_ADV, 6'h00, 8'd0);
        @(negedge clk);
        chk("adv0_ready", cmd_ready, 1);
        chk("adv0_running", running, 1);
        chk("adv0_count", chip_count, 2);
        cyc();
        send(OP_RET, 6'h00, 8'd0);
        pulse_step(2);
        @(negedge clk);
        chk("ret0_count", chip_count, 3);
        cyc();

        // Reset while 3 of 10 advance steps remain
        send(OP_ADV, 6'h00, 8'd10);
        for (int i = 0; i < 7; i++) begin
            push_step(3 + i);
            cyc();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_step", gen_step, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_running", running, 0);
        chk("midrst_count", chip_count, 0);
        chk("midrst_seed", gen_seed, 0);
        chk("midrst_load", gen_load, 0);
        chip_en = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        chip_en = 1'b0;
        @(negedge clk);
        chk("postrst_count", chip_count, 0);
        chk("postrst_running", running, 0);
        cyc();

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
